// File: rtl/tone_phase_gen.sv
// Tone generator: fetches a phase increment from the note ROM and runs a phase
// accumulator at a divided sample tick to drive a square-wave audio pin.
module tone_phase_gen #(
   parameter int ACC_W    = 20,
   parameter int TICK_DIV = 8192,
   parameter int ROM_LAT  = 1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [6:0]  note,
   input  logic        note_valid,
   output logic        note_ready,
   output logic [6:0]  rom_addr,
   input  logic [19:0] rom_dout,
   output logic        tick,
   output logic        note_active,
   output logic        audio_out
);

   localparam int CNT_W  = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
   localparam int WAIT_W = (ROM_LAT > 1) ? $clog2(ROM_LAT + 1) : 1;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_FETCH = 2'd1,
      ST_RUN   = 2'd2
   } state_t;

   state_t             state_r;
   state_t             state_nxt_s;
   logic [WAIT_W-1:0]  wait_r;
   logic [WAIT_W-1:0]  wait_nxt_s;
   logic [CNT_W-1:0]   cnt_r;
   logic [19:0]        inc_r;
   logic [19:0]        inc_nxt_s;
   logic [ACC_W-1:0]   acc_r;
   logic [ACC_W-1:0]   acc_nxt_s;
   logic [6:0]         rom_addr_r;
   logic               note_ready_r;
   logic               tick_r;
   logic               note_active_r;
   logic               audio_out_r;
   logic               accept_s;
   logic               load_s;

   assign accept_s    = note_valid & note_ready_r;
   assign note_ready  = note_ready_r;
   assign rom_addr    = rom_addr_r;
   assign tick        = tick_r;
   assign note_active = note_active_r;
   assign audio_out   = audio_out_r;

   // Free-running sample-tick divider; tick is registered one cycle ahead of the wrap.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_r  <= {CNT_W{1'b0}};
         tick_r <= 1'b0;
      end else begin
         if (cnt_r == CNT_W'(TICK_DIV - 1)) begin
            cnt_r <= {CNT_W{1'b0}};
         end else begin
            cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
         end
         tick_r <= (cnt_r == CNT_W'(TICK_DIV - 2));
      end
   end

   // Next-state logic for the note fetch sequence.
   always_comb begin
      state_nxt_s = state_r;
      wait_nxt_s  = wait_r;
      load_s      = 1'b0;
      case (state_r)
         ST_IDLE, ST_RUN: begin
            if (accept_s) begin
               state_nxt_s = ST_FETCH;
               wait_nxt_s  = {WAIT_W{1'b0}};
            end else begin
               state_nxt_s = state_r;
            end
         end
         ST_FETCH: begin
            if (wait_r == WAIT_W'(ROM_LAT)) begin
               load_s      = 1'b1;
               state_nxt_s = ST_RUN;
            end else begin
               wait_nxt_s  = wait_r + {{(WAIT_W-1){1'b0}}, 1'b1};
            end
         end
         default: begin
            state_nxt_s = ST_IDLE;
         end
      endcase
   end

   // Increment and accumulator next values; a zero increment clears the phase on load.
   always_comb begin
      inc_nxt_s = inc_r;
      acc_nxt_s = acc_r;
      if (load_s) begin
         inc_nxt_s = rom_dout;
      end else begin
         inc_nxt_s = inc_r;
      end
      if (load_s && (rom_dout == 20'd0)) begin
         acc_nxt_s = {ACC_W{1'b0}};
      end else if (tick_r && (state_r != ST_IDLE)) begin
         acc_nxt_s = acc_r + ACC_W'(inc_r);
      end else begin
         acc_nxt_s = acc_r;
      end
   end

   // FSM, phase state and ROM address registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r    <= ST_IDLE;
         wait_r     <= {WAIT_W{1'b0}};
         inc_r      <= 20'd0;
         acc_r      <= {ACC_W{1'b0}};
         rom_addr_r <= 7'd0;
      end else begin
         state_r <= state_nxt_s;
         wait_r  <= wait_nxt_s;
         inc_r   <= inc_nxt_s;
         acc_r   <= acc_nxt_s;
         if (accept_s) begin
            rom_addr_r <= note;
         end else begin
            rom_addr_r <= rom_addr_r;
         end
      end
   end

   // Registered outputs; ready drops on accept and returns the cycle after the load.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         note_ready_r  <= 1'b1;
         note_active_r <= 1'b0;
         audio_out_r   <= 1'b0;
      end else begin
         if (accept_s) begin
            note_ready_r <= 1'b0;
         end else begin
            note_ready_r <= (state_r != ST_FETCH);
         end
         note_active_r <= (inc_nxt_s != 20'd0);
         audio_out_r   <= acc_r[ACC_W-1] & note_active_r;
      end
   end

endmodule
